// File: rtl/pipe_stage_elastic_if.sv
// Handshake bundle between two pipeline stages.
// The master side is the upstream/downstream environment and the slave side
// is the elastic pipeline stage itself.
interface pipe_stage_elastic_if #(
    parameter int WIDTH = 168
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage pipeline register with valid/ready handshake.
// The main register always drives out_data.
// With SKID=1 a second skid register absorbs the word that arrives while
// downstream stalls, so in_ready can come straight from a flop.
// Flush squashes everything held and anything accepted in the same cycle.
module pipe_stage_elastic #(
    parameter int WIDTH      = 168,
    parameter int SKID       = 1,
    parameter int CLEAR_DATA = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    pipe_stage_elastic_if.slave   bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             in_ready_q;
    logic             in_ready_next;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] main_next;
    logic [WIDTH-1:0] skid_next;
    logic             in_fire;
    logic             out_fire;
    logic             load_in;
    logic             load_skid;
    logic             shift_skid;

    // Without a skid register, a stalled full stage must refuse input in
    // the same cycle; reset holds it low.
    assign bus.in_ready  = (SKID != 0) ? in_ready_q
                                       : (rst && ((state == EMPTY) || bus.out_ready));
    assign bus.out_valid = (state != EMPTY);
    assign bus.out_data  = main_q;
    assign bus.occupancy = state;

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = bus.out_valid && bus.out_ready;

    // Next-state and datapath steering; flush overrides every transfer.
    always_comb begin
        next_state = state;
        load_in    = 1'b0;
        load_skid  = 1'b0;
        shift_skid = 1'b0;
        main_next  = main_q;
        skid_next  = skid_q;

        if (bus.flush) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        load_in    = 1'b1;
                        next_state = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_in = 1'b1;
                    end else if (in_fire) begin
                        if (SKID != 0) begin
                            load_skid  = 1'b1;
                            next_state = TWO;
                        end else begin
                            load_in = 1'b1;
                        end
                    end else if (out_fire) begin
                        next_state = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        shift_skid = 1'b1;
                        next_state = ONE;
                    end
                end
                default: next_state = EMPTY;
            endcase
        end

        if (bus.flush) begin
            if (CLEAR_DATA != 0) begin
                main_next = '0;
                skid_next = '0;
            end
        end else begin
            if (load_in)    main_next = bus.in_data;
            if (shift_skid) main_next = skid_q;
            if (load_skid)  skid_next = bus.in_data;
        end

        in_ready_next = (next_state != TWO);
    end

    // State and registered in_ready; in_ready stays low through reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state      <= next_state;
            in_ready_q <= in_ready_next;
        end
    end

    generate
        if (CLEAR_DATA != 0) begin : g_clear
            // Payload registers that reset to zero.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    main_q <= '0;
                    skid_q <= '0;
                end else begin
                    main_q <= main_next;
                    skid_q <= skid_next;
                end
            end
        end else begin : g_keep
            // Payload registers without reset; valid alone marks them stale.
            always_ff @(posedge clk) begin
                main_q <= main_next;
                skid_q <= skid_next;
            end
        end
    endgenerate

endmodule
